// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: clk-domain synchronisers, one-word TX holding buffer,
// configurable width, CPOL/CPHA and bit order, with underrun/overrun flags.
`timescale 1ns/1ps
module spi_slave_param #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int   DW       = DATA_WIDTH;
    localparam int   CW       = $clog2(DW);
    localparam logic IDLE_LVL = (CPOL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic first_bit(input logic [DW-1:0] w);
        if (MSB_FIRST != 0) begin
            first_bit = w[DW-1];
        end else begin
            first_bit = w[0];
        end
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w);
        if (MSB_FIRST != 0) begin
            shift_out = {w[DW-2:0], 1'b0};
        end else begin
            shift_out = {1'b0, w[DW-1:1]};
        end
    endfunction

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic b);
        if (MSB_FIRST != 0) begin
            shift_in = {w[DW-2:0], b};
        end else begin
            shift_in = {b, w[DW-1:1]};
        end
    endfunction

    logic          sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic          cs_meta_r, cs_sync_r, cs_prev_r;
    logic          mosi_meta_r, mosi_sync_r;
    state_t        state_r, state_next_s;
    logic          load_s, sample_s, shift_s, abort_s;
    logic          lead_s, trail_s, cs_fall_s, cs_rise_s;
    logic          word_done_s, reload_s, tx_wr_s;
    logic [DW-1:0] rx_next_s, load_word_s;
    logic [DW-1:0] tx_buf_r, tx_shift_r, rx_shift_r, rx_data_r;
    logic [CW-1:0] bit_cnt_r;
    logic          tx_ready_r, tx_underrun_r, rx_valid_r, rx_overrun_r;
    logic          miso_r, miso_oe_r, busy_r;

    assign lead_s      = (sclk_sync_r != IDLE_LVL) && (sclk_prev_r == IDLE_LVL);
    assign trail_s     = (sclk_sync_r == IDLE_LVL) && (sclk_prev_r != IDLE_LVL);
    assign cs_fall_s   = cs_prev_r && !cs_sync_r;
    assign cs_rise_s   = !cs_prev_r && cs_sync_r;
    assign word_done_s = sample_s && (bit_cnt_r == CW'(DW - 1));
    assign reload_s    = load_s || word_done_s;
    assign tx_wr_s     = tx_valid && tx_ready_r;
    assign rx_next_s   = shift_in(rx_shift_r, mosi_sync_r);
    // tx_ready_r doubles as the buffer-empty flag
    assign load_word_s = tx_ready_r ? {DW{1'b0}} : tx_buf_r;

    // Two-flop synchronisers plus previous-value flops for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_meta_r <= IDLE_LVL;
            sclk_sync_r <= IDLE_LVL;
            sclk_prev_r <= IDLE_LVL;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            cs_meta_r   <= cs;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and per-cycle shifter controls
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        sample_s     = 1'b0;
        shift_s      = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_next_s = ST_ACTIVE;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_next_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else if (CPHA == 0) begin
                    // bit_cnt==0 here means the first bit of the next word is already out
                    sample_s = lead_s;
                    shift_s  = trail_s && (bit_cnt_r != {CW{1'b0}});
                end else begin
                    sample_s = trail_s;
                    shift_s  = lead_s;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // TX holding buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf_r      <= {DW{1'b0}};
            tx_ready_r    <= 1'b1;
            tx_underrun_r <= 1'b0;
        end else begin
            tx_underrun_r <= reload_s && tx_ready_r;
            if (reload_s && !tx_ready_r) begin
                tx_ready_r <= 1'b1;
            end else if (tx_wr_s) begin
                tx_buf_r   <= tx_data;
                tx_ready_r <= 1'b0;
            end
        end
    end

    // TX/RX shifters, bit counter and MISO driver
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_r <= {DW{1'b0}};
            rx_shift_r <= {DW{1'b0}};
            bit_cnt_r  <= {CW{1'b0}};
            miso_r     <= 1'b0;
        end else if (abort_s) begin
            tx_shift_r <= {DW{1'b0}};
            rx_shift_r <= {DW{1'b0}};
            bit_cnt_r  <= {CW{1'b0}};
            miso_r     <= 1'b0;
        end else begin
            if (reload_s) begin
                if (CPHA == 0) begin
                    miso_r     <= first_bit(load_word_s);
                    tx_shift_r <= shift_out(load_word_s);
                end else begin
                    tx_shift_r <= load_word_s;
                end
            end else if (shift_s) begin
                miso_r     <= first_bit(tx_shift_r);
                tx_shift_r <= shift_out(tx_shift_r);
            end
            if (load_s) begin
                bit_cnt_r <= {CW{1'b0}};
            end else if (sample_s) begin
                rx_shift_r <= rx_next_s;
                bit_cnt_r  <= word_done_s ? {CW{1'b0}} : bit_cnt_r + CW'(1);
            end
        end
    end

    // RX word output with overrun detection; completion beats the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r    <= {DW{1'b0}};
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            rx_overrun_r <= 1'b0;
            if (word_done_s) begin
                rx_data_r    <= rx_next_s;
                rx_valid_r   <= 1'b1;
                rx_overrun_r <= rx_valid_r && !rx_ready;
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    // Frame status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            miso_oe_r <= 1'b0;
        end else begin
            busy_r    <= (state_next_s == ST_ACTIVE);
            miso_oe_r <= (state_next_s == ST_ACTIVE);
        end
    end

    assign miso        = miso_r;
    assign miso_oe     = miso_oe_r;
    assign tx_ready    = tx_ready_r;
    assign tx_underrun = tx_underrun_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign rx_overrun  = rx_overrun_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: four instances covering modes 0-3 and both bit
// orders, a bit-banged SPI master, and queue scoreboards for MISO and RX words.
`timescale 1ns/1ps
module tb_spi_slave_param;

    localparam int NI   = 4;
    localparam int HALF = 6;

    typedef struct {
        int         inst;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] tx;
        logic [7:0] rx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk [NI];
    logic       cs [NI];
    logic       mosi [NI];
    logic       miso [NI];
    logic       miso_oe [NI];
    logic [7:0] tx_data [NI];
    logic       tx_valid [NI];
    logic       tx_ready [NI];
    logic       tx_underrun [NI];
    logic [7:0] rx_data [NI];
    logic       rx_valid [NI];
    logic       rx_ready [NI];
    logic       rx_overrun [NI];
    logic       busy [NI];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   under_cnt [NI];
    int   over_cnt [NI];
    exp_t rx_q[$];
    exp_t tx_q[$];
    vec_t vecs [6];

    always #5 clk = ~clk;

    // inst 0: mode 0 MSB, 1: mode 1 LSB, 2: mode 2 MSB, 3: mode 3 LSB
    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_slave_param #(
            .DATA_WIDTH(8),
            .CPOL(g / 2),
            .CPHA(g % 2),
            .MSB_FIRST(((g % 2) == 0) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk[g]), .cs(cs[g]), .mosi(mosi[g]),
            .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data[g]),
            .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_underrun(tx_underrun[g]),
            .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
            .rx_overrun(rx_overrun[g]), .busy(busy[g])
        );
    end

    function automatic logic cpol_of(input int m);
        return ((m / 2) % 2) != 0;
    endfunction

    function automatic logic cpha_of(input int m);
        return (m % 2) != 0;
    endfunction

    function automatic logic msb_of(input int m);
        return (m % 2) == 0;
    endfunction

    task automatic check(input string name, input int m, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", name, m, got, exp);
        end
    endtask

    // Scoreboard monitor: counts flag pulses and checks every RX handshake
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (tx_underrun[k] === 1'b1) under_cnt[k]++;
            if (rx_overrun[k] === 1'b1) over_cnt[k]++;
            if (rx_valid[k] === 1'b1 && rx_ready[k] === 1'b1) begin
                if (rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rx inst%0d: got 0x%0h expected no word", k, rx_data[k]);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_inst", k, 32'(k), 32'(e.inst));
                    check("rx_data", k, 32'(rx_data[k]), 32'(e.d));
                end
            end
        end
    end

    task automatic half_bit();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tx_write(input int m, input logic [7:0] d);
        int t = 0;
        while (tx_ready[m] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (tx_ready[m] !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_write_timeout inst%0d: got tx_ready=%b expected 1", m, tx_ready[m]);
        end else begin
            tx_data[m]  = d;
            tx_valid[m] = 1'b1;
            tx_q.push_back('{inst: m, d: d});
            @(negedge clk);
            tx_valid[m] = 1'b0;
        end
    endtask

    task automatic spi_bits(input int m, input logic [7:0] w, input int nb, output logic [7:0] cap);
        logic idle;
        int   idx;
        idle = cpol_of(m);
        cap  = 8'h00;
        for (int i = 0; i < nb; i++) begin
            idx = msb_of(m) ? 7 - i : i;
            if (!cpha_of(m)) begin
                mosi[m] = w[idx];
                half_bit();
                cap[idx] = miso[m];
                sclk[m]  = ~idle;
                half_bit();
                sclk[m]  = idle;
            end else begin
                sclk[m] = ~idle;
                mosi[m] = w[idx];
                half_bit();
                cap[idx] = miso[m];
                sclk[m]  = idle;
                half_bit();
            end
        end
    endtask

    task automatic frame(input int m, input int nw, input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] cap;
        exp_t       e;
        cs[m] = 1'b0;
        half_bit();
        half_bit();
        check("busy_active", m, 32'(busy[m]), 32'd1);
        check("miso_oe_active", m, 32'(miso_oe[m]), 32'd1);
        for (int k = 0; k < nw; k++) begin
            spi_bits(m, (k == 0) ? w0 : w1, 8, cap);
            if (tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL miso_word inst%0d: got 0x%0h expected no word queued", m, cap);
            end else begin
                e = tx_q.pop_front();
                check("miso_word", m, 32'(cap), 32'(e.d));
            end
        end
        half_bit();
        cs[m] = 1'b1;
        half_bit();
        check("busy_idle", m, 32'(busy[m]), 32'd0);
        check("miso_oe_idle", m, 32'(miso_oe[m]), 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (rx_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (rx_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_timeout: got %0d words pending expected 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input int m);
        check("rst_miso", m, 32'(miso[m]), 32'd0);
        check("rst_miso_oe", m, 32'(miso_oe[m]), 32'd0);
        check("rst_tx_ready", m, 32'(tx_ready[m]), 32'd1);
        check("rst_tx_underrun", m, 32'(tx_underrun[m]), 32'd0);
        check("rst_rx_data", m, 32'(rx_data[m]), 32'd0);
        check("rst_rx_valid", m, 32'(rx_valid[m]), 32'd0);
        check("rst_rx_overrun", m, 32'(rx_overrun[m]), 32'd0);
        check("rst_busy", m, 32'(busy[m]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         u0;
        int         o0;
        logic [7:0] cap;

        vecs[0] = '{inst: 0, tx: 8'h3C, rx: 8'hA5};
        vecs[1] = '{inst: 1, tx: 8'h81, rx: 8'h5A};
        vecs[2] = '{inst: 2, tx: 8'h81, rx: 8'h5A};
        vecs[3] = '{inst: 3, tx: 8'h81, rx: 8'h5A};
        vecs[4] = '{inst: 1, tx: 8'h3C, rx: 8'hA5};
        vecs[5] = '{inst: 3, tx: 8'hE2, rx: 8'h1B};

        rst = 1'b1;
        for (int m = 0; m < NI; m++) begin
            sclk[m]     = cpol_of(m);
            cs[m]       = 1'b1;
            mosi[m]     = 1'b0;
            tx_data[m]  = 8'h00;
            tx_valid[m] = 1'b0;
            rx_ready[m] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int m = 0; m < NI; m++) check_reset_outputs(m);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single-word frames in every mode; empty buffer at end-of-word reload
        for (int v = 0; v < 6; v++) begin
            u0 = under_cnt[vecs[v].inst];
            tx_write(vecs[v].inst, vecs[v].tx);
            rx_q.push_back('{inst: vecs[v].inst, d: vecs[v].rx});
            frame(vecs[v].inst, 1, vecs[v].rx, 8'h00);
            drain();
            check("underrun_end", vecs[v].inst, 32'(under_cnt[vecs[v].inst] - u0), 32'd1);
        end

        // two words in one frame, buffer refilled while the first shifts
        tx_write(0, 8'h11);
        rx_q.push_back('{inst: 0, d: 8'hC3});
        rx_q.push_back('{inst: 0, d: 8'h5E});
        fork
            frame(0, 2, 8'hC3, 8'h5E);
            tx_write(0, 8'h22);
        join
        drain();

        // empty buffer at frame start: zeros on MISO, underrun at start and end
        check("buf_empty", 0, 32'(tx_ready[0]), 32'd1);
        u0 = under_cnt[0];
        tx_q.push_back('{inst: 0, d: 8'h00});
        rx_q.push_back('{inst: 0, d: 8'h96});
        frame(0, 1, 8'h96, 8'h00);
        drain();
        check("underrun_start", 0, 32'(under_cnt[0] - u0), 32'd2);

        // consumer stalled across two words
        rx_ready[2] = 1'b0;
        o0 = over_cnt[2];
        tx_q.push_back('{inst: 2, d: 8'h00});
        tx_q.push_back('{inst: 2, d: 8'h00});
        frame(2, 2, 8'h3A, 8'hC5);
        check("overrun_cnt", 2, 32'(over_cnt[2] - o0), 32'd1);
        check("overrun_valid", 2, 32'(rx_valid[2]), 32'd1);
        check("overrun_data", 2, 32'(rx_data[2]), 32'hC5);
        rx_q.push_back('{inst: 2, d: 8'hC5});
        rx_ready[2] = 1'b1;
        drain();
        repeat (2) @(negedge clk);
        check("rx_valid_clear", 2, 32'(rx_valid[2]), 32'd0);

        // aborted frame after 3 bits, then a full word must assemble cleanly
        cs[0] = 1'b0;
        half_bit();
        half_bit();
        spi_bits(0, 8'hE7, 3, cap);
        half_bit();
        cs[0] = 1'b1;
        half_bit();
        check("abort_rx_valid", 0, 32'(rx_valid[0]), 32'd0);
        check("abort_busy", 0, 32'(busy[0]), 32'd0);
        check("abort_miso_oe", 0, 32'(miso_oe[0]), 32'd0);
        check("abort_miso", 0, 32'(miso[0]), 32'd0);
        tx_write(0, 8'h5C);
        rx_q.push_back('{inst: 0, d: 8'h69});
        frame(0, 1, 8'h69, 8'h00);
        drain();

        // reset in the middle of a frame
        cs[0] = 1'b0;
        half_bit();
        half_bit();
        spi_bits(0, 8'hFF, 3, cap);
        rst = 1'b1;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        cs[0]   = 1'b1;
        sclk[0] = cpol_of(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 0, 32'(busy[0]), 32'd0);
        check("post_rst_rx_valid", 0, 32'(rx_valid[0]), 32'd0);
        check("post_rst_tx_ready", 0, 32'(tx_ready[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
